// File: rtl/pll_reset_sequencer_pkg.sv
// pll_seq_pkg: shared types and widths for the PLL reset sequencer.
// State encodings are fixed because state_o exposes them for debug.
package pll_seq_pkg;

  localparam int STATE_W    = 3;
  localparam int RETRY_W    = 4;
  localparam int LOSS_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_e;

  function automatic int max3(input int a,
                              input int b,
                              input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// pll_seq_if: control/status bundle of the PLL reset sequencer.
// slave = sequencer side; master = supervisor/consumer side.
// loss_cnt_o exists only when PLL_SEQ_LOSS_CNT_EN is defined.
interface pll_seq_if;
  import pll_seq_pkg::*;

  logic               pll_lock_i;
  logic               restart_i;
  logic               pll_reset_o;
  logic               sys_rst_n_o;
  logic               ready_o;
  logic               fail_o;
  logic [RETRY_W-1:0] retry_cnt_o;
  logic [STATE_W-1:0] state_o;
`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_o;

  modport slave (
    input  pll_lock_i, restart_i,
    output pll_reset_o, sys_rst_n_o,
    output ready_o, fail_o,
    output retry_cnt_o, state_o,
    output loss_cnt_o
  );

  modport master (
    output pll_lock_i, restart_i,
    input  pll_reset_o, sys_rst_n_o,
    input  ready_o, fail_o,
    input  retry_cnt_o, state_o,
    input  loss_cnt_o
  );
`else
  modport slave (
    input  pll_lock_i, restart_i,
    output pll_reset_o, sys_rst_n_o,
    output ready_o, fail_o,
    output retry_cnt_o, state_o
  );

  modport master (
    output pll_lock_i, restart_i,
    input  pll_reset_o, sys_rst_n_o,
    input  ready_o, fail_o,
    input  retry_cnt_o, state_o
  );
`endif

endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// sync_2ff: generic two-flop synchronizer, async active-low reset to 0.
// Ports: clk, rst_n, d_i (async input), q_o (synchronized output).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: drives PLL RESET, qualifies LOCK, retries, FAIL.
// Ports: clk, rst_n, bus (pll_seq_if.slave). Option: PLL_SEQ_LOSS_CNT_EN.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 27000,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  pll_seq_if.slave bus
);

  localparam int CNT_MAX =
    max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CNT_W =
    (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX =
    RETRY_W'(MAX_RETRIES);

  logic lock_s;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [RETRY_W-1:0] retry_inc;
  logic               pll_reset_q, pll_reset_d;
  logic               sys_rst_n_q, sys_rst_n_d;
  logic               ready_q, ready_d;
  logic               fail_q, fail_d;
`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
`endif

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.pll_lock_i),
    .q_o   (lock_s)
  );

  assign retry_inc = retry_q + RETRY_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
`ifdef PLL_SEQ_LOSS_CNT_EN
    loss_d  = loss_q;
`endif

    if (bus.restart_i) begin
      state_d = PLL_RST;
      retry_d = '0;
    end else begin
      unique case (state_q)
        PLL_RST: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == RST_LAST)
            state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          cnt_d = cnt_q + CNT_W'(1);
          // Lock seen on the timeout cycle still wins.
          if (lock_s) begin
            state_d = STABLE;
          end else if (cnt_q == TMO_LAST) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_MAX)
                    ? FAIL : PLL_RST;
          end
        end
        STABLE: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!lock_s)
            state_d = WAIT_LOCK;
          else if (cnt_q == STB_LAST)
            state_d = RUN;
        end
        RUN: begin
          // Lock loss after a good run: fresh retry budget.
          if (!lock_s) begin
            state_d = PLL_RST;
            retry_d = '0;
`ifdef PLL_SEQ_LOSS_CNT_EN
            if (loss_q != '1)
              loss_d = loss_q + LOSS_CNT_W'(1);
`endif
          end
        end
        FAIL: begin
          state_d = FAIL;
        end
        default: begin
          state_d = PLL_RST;
        end
      endcase
    end

    // Counter restarts on every state entry, re-entry included.
    if (bus.restart_i || (state_d != state_q))
      cnt_d = '0;
  end

  // Outputs decoded from next state so they move with state_q.
  always_comb begin
    pll_reset_d = (state_d == PLL_RST) ||
                  (state_d == FAIL);
    sys_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
    fail_d      = (state_d == FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

`ifdef PLL_SEQ_LOSS_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      loss_q <= '0;
    else
      loss_q <= loss_d;
  end

  assign bus.loss_cnt_o = loss_q;
`endif

  assign bus.pll_reset_o = pll_reset_q;
  assign bus.sys_rst_n_o = sys_rst_n_q;
  assign bus.ready_o     = ready_q;
  assign bus.fail_o      = fail_q;
  assign bus.retry_cnt_o = retry_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed checks of the PLL reset sequencer.
// RST=4, TIMEOUT=20, STABLE=8, MAX_RETRIES=2; edges counted after release.
module tb_pll_reset_sequencer;
  import pll_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  pll_seq_if bus ();

  pll_reset_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {pll_reset, sys_rst_n, ready, fail, retry[3:0], state[2:0]}
  logic [10:0] obs;
  assign obs = {bus.pll_reset_o, bus.sys_rst_n_o,
                bus.ready_o, bus.fail_o,
                bus.retry_cnt_o, bus.state_o};

  function automatic logic [10:0] ev(
    input logic pr, input logic sr,
    input logic rd, input logic fl,
    input logic [3:0] rc, input logic [2:0] st);
    return {pr, sr, rd, fl, rc, st};
  endfunction

  task automatic chk(input string tag,
                     input logic [10:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag,
                      input logic [7:0] o,
                      input logic [7:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, o, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.pll_lock_i = 1'b0;
    bus.restart_i  = 1'b0;
    tick(2);
    chk("reset", ev(1,0,0,0,0,PLL_RST));
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal bring-up
    tick(3);
    chk("rst_hold", ev(1,0,0,0,0,PLL_RST));
    tick(1);
    chk("wait_entry", ev(0,0,0,0,0,WAIT_LOCK));
    tick(5);
    bus.pll_lock_i = 1'b1;  // sampled at edge 10
    tick(2);
    chk("sync_lat", ev(0,0,0,0,0,WAIT_LOCK));
    tick(1);
    chk("stable_entry", ev(0,0,0,0,0,STABLE));
    tick(7);
    chk("stable_hold", ev(0,0,0,0,0,STABLE));
    tick(1);
    chk("run_entry", ev(0,1,1,0,0,RUN));

    // Lock loss in RUN (edge 20)
    bus.pll_lock_i = 1'b0;
    tick(2);
    chk("run_hold", ev(0,1,1,0,0,RUN));
    tick(1);
    chk("loss_rst", ev(1,0,0,0,0,PLL_RST));
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk8("loss_cnt1", bus.loss_cnt_o, 8'd1);
`endif
    bus.pll_lock_i = 1'b1;
    tick(3);
    chk("loss_rst_hold", ev(1,0,0,0,0,PLL_RST));
    tick(1);
    chk("relock_wait", ev(0,0,0,0,0,WAIT_LOCK));
    tick(1);
    chk("relock_stable", ev(0,0,0,0,0,STABLE));
    tick(8);
    chk("relock_run", ev(0,1,1,0,0,RUN));

    // restart_i coincides with lock-loss transition
    bus.pll_lock_i = 1'b0;
    tick(2);
    bus.restart_i = 1'b1;
    tick(1);
    bus.restart_i = 1'b0;
    chk("restart_vs_loss", ev(1,0,0,0,0,PLL_RST));

    // Glitchy lock in STABLE
    bus.pll_lock_i = 1'b1;
    tick(5);
    chk("glitch_stable", ev(0,0,0,0,0,STABLE));
    tick(3);
    bus.pll_lock_i = 1'b0;
    tick(1);
    bus.pll_lock_i = 1'b1;
    tick(1);
    chk("glitch_5hi", ev(0,0,0,0,0,STABLE));
    tick(1);
    chk("glitch_back", ev(0,0,0,0,0,WAIT_LOCK));
    tick(1);
    chk("glitch_restb", ev(0,0,0,0,0,STABLE));
    tick(7);
    chk("glitch_7hi", ev(0,0,0,0,0,STABLE));
    tick(1);
    chk("glitch_run", ev(0,1,1,0,0,RUN));

    // Async reset mid-RUN, no clock edge needed
    #2 rst_n = 1'b0;
    #1 chk("async_rst", ev(1,0,0,0,0,PLL_RST));
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk8("loss_cnt_rst", bus.loss_cnt_o, 8'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    chk("rerst_hold", ev(1,0,0,0,0,PLL_RST));
    tick(1);
    chk("rerst_wait", ev(0,0,0,0,0,WAIT_LOCK));

    // Restart beats lock_s=1 in WAIT_LOCK; then time out
    bus.pll_lock_i = 1'b0;
    bus.restart_i  = 1'b1;
    tick(1);
    bus.restart_i  = 1'b0;
    chk("restart_wait", ev(1,0,0,0,0,PLL_RST));
    tick(23);
    chk("tmo_edge", ev(0,0,0,0,0,WAIT_LOCK));
    tick(1);
    chk("tmo1", ev(1,0,0,0,1,PLL_RST));
    tick(3);
    chk("tmo1_hold", ev(1,0,0,0,1,PLL_RST));
    tick(1);
    chk("tmo1_wait", ev(0,0,0,0,1,WAIT_LOCK));
    tick(19);
    chk("tmo2_edge", ev(0,0,0,0,1,WAIT_LOCK));
    tick(1);
    chk("fail", ev(1,0,0,1,2,FAIL));
    tick(10);
    chk("fail_hold", ev(1,0,0,1,2,FAIL));
    bus.restart_i = 1'b1;
    tick(1);
    bus.restart_i = 1'b0;
    chk("fail_restart", ev(1,0,0,0,0,PLL_RST));

    // Lock arrives on last timeout cycle
    tick(24);
    chk("c_tmo1", ev(1,0,0,0,1,PLL_RST));
    tick(21);
    bus.pll_lock_i = 1'b1;  // lock_s high at edge 48
    tick(2);
    chk("c_last", ev(0,0,0,0,1,WAIT_LOCK));
    tick(1);
    chk("c_lockwins", ev(0,0,0,0,1,STABLE));
    tick(8);
    chk("c_run", ev(0,1,1,0,1,RUN));

    // Lock loss in RUN clears retry count
    bus.pll_lock_i = 1'b0;
    tick(3);
    chk("c_loss_clr", ev(1,0,0,0,0,PLL_RST));
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk8("loss_cnt2", bus.loss_cnt_o, 8'd1);
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
